counter_control: RTL

COUNTER_CONTROL -- requirements
Module: counter_control

---
 rtl/counter_ctrl_pkg.sv | 13 +
 rtl/counter_control_rise_detect.sv | 18 +
 rtl/counter_control.sv | 103 ++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared widths, FSM state encoding and count range limit for counter_control.
package counter_ctrl_pkg;
    localparam int CNT_W  = 16;
    localparam int ROLL_W = 4;
    localparam int ST_W   = 3;
    localparam int BUZZ_W = 4;
    localparam logic [CNT_W-1:0] COUNT_MAX = 16'd9999;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd1;
    localparam logic [ST_W-1:0] ST_PAUSE = 3'd2;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd3;
    localparam logic [ST_W-1:0] ST_ALARM = 3'd4;
endpackage

// File: rtl/counter_control_rise_detect.sv
// rise_detect: registered 1-bit rising-edge detector; rise is high when d is 1 and was 0 last sample.
module rise_detect (
    input  logic clk_1Hz,
    input  logic result_reset,
    input  logic d,
    output logic rise
);
    logic prev_q, prev_d;

    always_comb begin
        prev_d = d;
        rise   = d & ~prev_q;
    end

    always_ff @(posedge clk_1Hz or posedge result_reset)
        if (result_reset) prev_q <= 1'b0;
        else              prev_q <= prev_d;
endmodule

// File: rtl/counter_control.sv
// counter_control: button-driven run/pause/load/alarm controller for an external BCD counter.
// Define COUNTER_CTRL_AUTOSTOP_EN to make ALARM exit to PAUSE once MAX_ROLLOVERS is reached.
module counter_control
    import counter_ctrl_pkg::*;
#(
    parameter int BUZZ_CYCLES   = 3,
    parameter int MAX_ROLLOVERS = 4
) (
    input  logic              clk_1Hz,
    input  logic              result_reset,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_load,
    input  logic              btn_mode,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              buzzer_in,
    output logic              state,
    output logic              updown,
    output logic              result_load,
    output logic              buzzer_out,
    output logic [ROLL_W-1:0] rollover_cnt,
    output logic              count_err,
    output logic [ST_W-1:0]   fsm_state
);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES - 1);

    logic start_r, stop_r, load_r, mode_r, buz_rise, auto_stop;
    logic [ST_W-1:0]   fsm_q, fsm_d;
    logic [BUZZ_W-1:0] buzz_q, buzz_d;
    logic [ROLL_W-1:0] roll_q, roll_d;
    logic updown_q, updown_d, from_run_q, from_run_d, err_q, err_d, buz_prev_q, buz_prev_d;

    rise_detect u_start (.clk_1Hz(clk_1Hz), .result_reset(result_reset), .d(btn_start), .rise(start_r));
    rise_detect u_stop  (.clk_1Hz(clk_1Hz), .result_reset(result_reset), .d(btn_stop),  .rise(stop_r));
    rise_detect u_load  (.clk_1Hz(clk_1Hz), .result_reset(result_reset), .d(btn_load),  .rise(load_r));
    rise_detect u_mode  (.clk_1Hz(clk_1Hz), .result_reset(result_reset), .d(btn_mode),  .rise(mode_r));

`ifdef COUNTER_CTRL_AUTOSTOP_EN
    assign auto_stop = roll_q >= ROLL_W'(MAX_ROLLOVERS);
`else
    assign auto_stop = (roll_q >= ROLL_W'(MAX_ROLLOVERS)) & 1'b0;
`endif

    // The if/else chains below encode stop > load > start > mode.
    always_comb begin
        buz_prev_d = buzzer_in;
        buz_rise   = buzzer_in & ~buz_prev_q;
        fsm_d      = fsm_q;
        updown_d   = updown_q;
        from_run_d = from_run_q;
        buzz_d     = buzz_q;
        err_d      = err_q | (count_in > COUNT_MAX);
        roll_d     = ((fsm_q == ST_RUN || fsm_q == ST_ALARM) && buz_rise && roll_q != 4'd15) ? roll_q + 4'd1 : roll_q;
        case (fsm_q)
            ST_IDLE, ST_PAUSE: begin
                if (stop_r)       fsm_d = fsm_q;
                else if (load_r)  begin fsm_d = ST_LOAD; from_run_d = 1'b0; end
                else if (start_r) fsm_d = ST_RUN;
                else if (mode_r)  updown_d = ~updown_q;
            end
            ST_RUN: begin
                if (stop_r)        fsm_d = ST_PAUSE;
                else if (load_r)   begin fsm_d = ST_LOAD; from_run_d = 1'b1; end
                else if (buz_rise) begin fsm_d = ST_ALARM; buzz_d = BUZZ_LOAD; end
            end
            ST_LOAD: fsm_d = from_run_q ? ST_RUN : ST_PAUSE;
            ST_ALARM: begin
                if (stop_r)            fsm_d = ST_PAUSE;
                else if (buz_rise)     buzz_d = BUZZ_LOAD;
                else if (buzz_q == '0) fsm_d = auto_stop ? ST_PAUSE : ST_RUN;
                else                   buzz_d = buzz_q - 4'd1;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge result_reset)
        if (result_reset) begin
            fsm_q      <= ST_IDLE;
            updown_q   <= 1'b1;
            from_run_q <= 1'b0;
            buzz_q     <= '0;
            roll_q     <= '0;
            err_q      <= 1'b0;
            buz_prev_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            updown_q   <= updown_d;
            from_run_q <= from_run_d;
            buzz_q     <= buzz_d;
            roll_q     <= roll_d;
            err_q      <= err_d;
            buz_prev_q <= buz_prev_d;
        end

    assign state        = (fsm_q == ST_IDLE) || (fsm_q == ST_PAUSE);
    assign updown       = updown_q;
    assign result_load  = fsm_q == ST_LOAD;
    assign buzzer_out   = fsm_q == ST_ALARM;
    assign rollover_cnt = roll_q;
    assign count_err    = err_q;
    assign fsm_state    = fsm_q;
endmodule
